// File: rtl/paint_pkg.sv
// Shared definitions for the paint framebuffer (160x120 pixels, 12-bit colour).
// Provides the address/data widths, the pixel count, the pixel and address
// types, and the write-arbiter state encoding.
package paint_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 19200;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } fbarb_state_t;

  // Highest valid pixel address; the fill counter stops here.
  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  // True when the address lands inside the visible picture.
  function automatic logic addr_in_range(input addr_t a);
    return a < addr_t'(DEPTH);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   req[1:0]    - request per client
//   en          - a grant is really issued this cycle; only then does the
//                 served-last pointer move
//   pick[1:0]   - one-hot winner (combinational), zero when nobody requests
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] pick
);

  // Index of the client served last. Resets to 1 so client 0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase

    last_d = last_q;
    if (en && (req != 2'b00)) begin
      last_d = pick[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owner of the single framebuffer RAM port.
// The display scan-out always wins while screen_on is high; during blanking
// the port is shared round-robin between the cursor painter (client 0) and the
// bulk writer (client 1), or used by the built-in full-screen fill sequencer.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   screen_on, disp_addr       - scan-out active flag and read address
//   req, wr_addr0/1, wr_data0/1 - client write requests
//   gnt                        - one-hot grant, the write happens that cycle
//   clear_start, clear_colour  - start a fill with the given colour
//   clear_busy                 - fill in progress
//   ram_a, ram_we, ram_wd      - RAM port (combinational)
module fb_write_arbiter
  import paint_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_on,
  input  addr_t       disp_addr,
  input  logic [1:0]  req,
  input  addr_t       wr_addr0,
  input  addr_t       wr_addr1,
  input  pixel_t      wr_data0,
  input  pixel_t      wr_data1,
  output logic [1:0]  gnt,
  input  logic        clear_start,
  input  pixel_t      clear_colour,
  output logic        clear_busy,
  output addr_t       ram_a,
  output logic        ram_we,
  output pixel_t      ram_wd
);

  fbarb_state_t state_q, state_d;
  addr_t        clr_cnt_q, clr_cnt_d;
  pixel_t       colour_q, colour_d;

  logic [1:0] pick;
  logic       arb_en;
  logic       we_raw;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (arb_en),
    .pick  (pick)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    colour_d  = colour_q;
    ram_a     = disp_addr;
    ram_wd    = '0;
    we_raw    = 1'b0;
    arb_en    = 1'b0;

    case (state_q)
      S_RUN: begin
        // A fill request is taken even during scan-out; it costs the
        // clients this cycle.
        if (clear_start) begin
          colour_d  = clear_colour;
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end else if (!screen_on && (req != 2'b00)) begin
          arb_en = !reset;
          ram_a  = pick[1] ? wr_addr1 : wr_addr0;
          ram_wd = pick[1] ? wr_data1 : wr_data0;
          // Out-of-range writes are granted (so the client moves on) but
          // never reach the RAM.
          we_raw = addr_in_range(ram_a);
        end
      end
      S_CLEAR: begin
        if (!screen_on) begin
          ram_a  = clr_cnt_q;
          ram_wd = colour_q;
          we_raw = 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            clr_cnt_d = '0;
            state_d   = S_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + addr_t'(1);
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign gnt        = arb_en ? pick : 2'b00;
  assign ram_we     = we_raw && !reset;
  assign clear_busy = (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      clr_cnt_q <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      colour_q  <= colour_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;
  import paint_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       screen_on;
  addr_t      disp_addr;
  logic [1:0] req;
  addr_t      wr_addr0, wr_addr1;
  pixel_t     wr_data0, wr_data1;
  logic [1:0] gnt;
  logic       clear_start;
  pixel_t     clear_colour;
  logic       clear_busy;
  addr_t      ram_a;
  logic       ram_we;
  pixel_t     ram_wd;

  fb_write_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .screen_on    (screen_on),
    .disp_addr    (disp_addr),
    .req          (req),
    .wr_addr0     (wr_addr0),
    .wr_addr1     (wr_addr1),
    .wr_data0     (wr_data0),
    .wr_data1     (wr_data1),
    .gnt          (gnt),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .ram_a        (ram_a),
    .ram_we       (ram_we),
    .ram_wd       (ram_wd)
  );

  always #5 clk = ~clk;

  // RAM model with per-address write counters.
  pixel_t      mem  [0:DEPTH-1];
  int unsigned wcnt [0:DEPTH-1];
  int unsigned total_writes = 0;
  logic        clr_counts = 1'b0;

  always @(posedge clk) begin
    if (clr_counts) begin
      for (int i = 0; i < DEPTH; i++) wcnt[i] <= 0;
    end else if (ram_we && (int'(ram_a) < DEPTH)) begin
      mem[ram_a]   <= ram_wd;
      wcnt[ram_a]  <= wcnt[ram_a] + 1;
      total_writes <= total_writes + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int unsigned w0;
  int          cyc;
  int          gnt_viol, port_viol, bad_addr, guard;
  logic        second_done;

  initial begin
    reset = 1'b1; screen_on = 1'b0; disp_addr = '0; req = 2'b11;
    wr_addr0 = addr_t'(10); wr_addr1 = addr_t'(20);
    wr_data0 = 12'hAAA; wr_data1 = 12'h555;
    clear_start = 1'b0; clear_colour = '0;

    // Reset: no grants or writes while reset is high.
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("rst_gnt", gnt, 0);
      chk("rst_we", ram_we, 0);
    end
    chk("rst_busy", clear_busy, 0);
    reset = 1'b0;

    // Display priority with both clients requesting.
    screen_on = 1'b1; disp_addr = addr_t'(100);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("disp_a", ram_a, 100);
      chk("disp_we", ram_we, 0);
      chk("disp_gnt", gnt, 0);
      tick();
    end

    // Blanking tie: alternate starting with client 0.
    screen_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_gnt", gnt, (i % 2 == 0) ? 1 : 2);
      chk("rr_wd", ram_wd, (i % 2 == 0) ? 12'hAAA : 12'h555);
      chk("rr_a", ram_a, (i % 2 == 0) ? 10 : 20);
      chk("rr_we", ram_we, 1);
      tick();
    end
    req = 2'b00;
    settle();
    chk("rr_mem10", mem[10], 12'hAAA);
    chk("rr_mem20", mem[20], 12'h555);
    chk("idle_a", ram_a, 100);
    chk("idle_we", ram_we, 0);

    // Out-of-range address: granted, not written.
    req = 2'b01; wr_addr0 = addr_t'(DEPTH); wr_data0 = 12'h123;
    w0 = total_writes;
    settle();
    chk("oor_gnt", gnt, 1);
    chk("oor_we", ram_we, 0);
    tick();
    chk("oor_nowrite", total_writes - w0, 0);
    wr_addr0 = addr_t'(DEPTH - 1);
    settle();
    chk("top_we", ram_we, 1);
    tick();
    chk("top_mem", mem[DEPTH-1], 12'h123);
    req = 2'b10;
    settle();
    chk("solo1_gnt", gnt, 2);
    tick();
    req = 2'b00;

    // Full-screen fill with the display toggling.
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    req = 2'b11; wr_addr0 = addr_t'(5); wr_addr1 = addr_t'(6);
    clear_start = 1'b1; clear_colour = 12'hF00;
    settle();
    chk("cs_gnt", gnt, 0);
    chk("cs_we", ram_we, 0);
    chk("cs_busy", clear_busy, 0);
    tick();
    clear_start = 1'b0;
    settle();
    chk("cs_busy_rise", clear_busy, 1);
    cyc = 0; gnt_viol = 0; port_viol = 0; second_done = 1'b0;
    w0 = total_writes;
    while (clear_busy === 1'b1 && cyc < 40000) begin
      screen_on   = ((cyc / 10) % 2 == 0);
      disp_addr   = addr_t'(cyc % 7000);
      clear_start = 1'b0;
      if (!second_done && !screen_on && (total_writes - w0 == 500)) begin
        clear_start  = 1'b1;
        clear_colour = 12'h0F0;
        second_done  = 1'b1;
      end
      settle();
      if (gnt != 2'b00) gnt_viol++;
      if (screen_on && (ram_a != disp_addr || ram_we)) port_viol++;
      if (!screen_on && !ram_we) port_viol++;
      tick();
      cyc++;
    end
    clear_start = 1'b0;
    chk("fill_busy_cycles", cyc, 38400);
    chk("fill_restart_tried", second_done, 1);
    chk("fill_no_gnt", gnt_viol, 0);
    chk("fill_port", port_viol, 0);
    chk("fill_writes", total_writes - w0, DEPTH);
    bad_addr = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (wcnt[a] != 1 || mem[a] != 12'hF00) bad_addr++;
    end
    chk("fill_bad_addr", bad_addr, 0);
    screen_on = 1'b0; req = 2'b01;
    settle();
    chk("post_fill_gnt", gnt, 1);
    tick();
    req = 2'b00;

    // Reset in the middle of a fill.
    clear_start = 1'b1; clear_colour = 12'h00F;
    tick();
    clear_start = 1'b0;
    w0 = total_writes; guard = 0;
    while ((total_writes - w0 < 1000) && guard < 5000) begin
      tick();
      guard++;
    end
    chk("mid_writes", total_writes - w0, 1000);
    reset = 1'b1; req = 2'b01; wr_addr0 = addr_t'(50); wr_data0 = 12'hABC;
    settle();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_we", ram_we, 0);
    tick();
    reset = 1'b0; screen_on = 1'b1;
    settle();
    chk("mid_busy", clear_busy, 0);
    chk("mid_disp_gnt", gnt, 0);
    tick();
    screen_on = 1'b0;
    settle();
    chk("mid_gnt", gnt, 1);
    chk("mid_we", ram_we, 1);
    chk("mid_a", ram_a, 50);
    tick();
    req = 2'b00;
    settle();
    chk("mid_mem999", mem[999], 12'h00F);
    chk("mid_mem1000", mem[1000], 12'hF00);
    chk("mid_mem50", mem[50], 12'hABC);
    chk("mid_idle_busy", clear_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
